seq_sm_multiplier: RTL and testbench
====================================

// Module: seq_sm_multiplier
// PURPOSE
//  Parametrised sequential shift-add multiplier; successor to the fixed 8-bit unit.
//  Accepts sign-magnitude or two's-complement operands (MODE), multiplies the
//  magnitudes serially with early termination, returns sign-magnitude and
//  two's-complement products plus the display sign code, under start/busy/done.
//  Sits between operand entry registers and the BCD/7-seg display path.
// PARAMETERS
//  WIDTH  8  operand width incl. sign bit; product magnitude is 2*WIDTH bits
// PORTS
//  clock         in   1          rising-edge clock
//  rst           in   1          synchronous active-high reset
//  start         in   1          request; sampled only in IDLE or DONE
//  mode          in   1          0 = sign-magnitude operands, 1 = two's complement
//  multiplicand  in   WIDTH      operand A, captured on accepted start
//  multiplier    in   WIDTH      operand B, captured on accepted start
//  busy          out  1          high in RUN
//  done          out  1          one-cycle pulse, product valid
//  result        out  2*WIDTH    product magnitude, held until next accepted start
//  product_tc    out  2*WIDTH    signed two's-complement product, held likewise
//  sign          out  4          4'b1010 negative, 4'b1100 positive/zero
//  zflag         out  1          high when result == 0
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, result=0, product_tc=0, sign=4'b1100,
//    zflag=1; internal shift regs and accumulator cleared. rst beats start.
//  - Capture on accepted start (mode, operands sampled once; later changes ignored):
//    mode0: magA={1'b0,A[W-2:0]}, magB likewise; neg = A[W-1]^B[W-1].
//    mode1: mag = two's-complement abs in WIDTH bits unsigned (-2^(W-1) -> 2^(W-1));
//    neg = A[W-1]^B[W-1].
//    mcand_sh <= zero-extended magA (2*WIDTH); mplr_sh <= magB; acc <= 0.
//  - FSM: IDLE -start-> RUN (or DONE directly if magB==0).
//    RUN, each cycle: if mplr_sh[0] acc <= acc + mcand_sh; mcand_sh <<= 1;
//    mplr_sh >>= 1; if shifted mplr_sh == 0 -> DONE, else stay.
//    DONE (1 cycle): done=1; result<=acc; product_tc <= (negz ? -acc : acc);
//    start here is accepted (back-to-back) -> RUN/DONE; else -> IDLE.
//  - Latency: start sampled at edge E0; n = index of highest set bit of magB + 1
//    (n=0 if magB==0); busy high for n cycles; done high during cycle after edge
//    E0+n+1... i.e. done visible after edge E0+n+1. Max WIDTH+1 cycles.
//  - Sign: negz = neg & (acc != 0); zero product always positive (sign=4'b1100).
//  - Outputs result/product_tc/sign/zflag update only in DONE; hold otherwise.
//  - Accumulator width 2*WIDTH; max magnitude 2^(2W-2) fits, no overflow possible.
//  - start during RUN ignored, no queueing. rst during RUN: abort, reset values
//    next cycle, no done pulse.
// TESTING (WIDTH=8)
//  1. mode0, A=0x85(-5), B=0x07(+7) -> done at E0+4, result=35, sign=1010,
//     product_tc=0xFFDD, zflag=0, busy high 3 cycles.
//  2. mode1, A=0x80, B=0x80 (-128*-128) -> done at E0+9, result=0x4000,
//     product_tc=0x4000, sign=1100.
//  3. mode0, A=0x83, B=0x00 -> done at E0+1, busy never high, result=0,
//     zflag=1, sign=1100 (neg zero suppressed).
//  4. mode1, A=0x03, B=0xFD (3*-3), then start with A=0x7F,B=0x7F mid-RUN ->
//     second start ignored; result=9, product_tc=0xFFF7, sign=1010.
//  5. rst asserted at RUN cycle 2 of A=0x7F,B=0x7F -> next cycle busy=0,
//     result=0, no done; following start 0x02*0x03 gives result=6.
//  6. start held high through DONE of 2*3 with new operands 4*5 -> second run
//     starts without IDLE gap; result=6 then result=20, two done pulses.

Source files
------------

// File: rtl/seq_sm_multiplier_if.sv
// Handshake and result bundle between the operand entry registers and the
// sequential sign-magnitude multiplier.
interface seq_sm_multiplier_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;
    logic [2*WIDTH-1:0]   product_tc;
    logic [3:0]           sign;
    logic                 zflag;

    modport master (
        output start, mode, multiplicand, multiplier,
        input  busy, done, result, product_tc, sign, zflag
    );

    modport slave (
        input  start, mode, multiplicand, multiplier,
        output busy, done, result, product_tc, sign, zflag
    );
endinterface

// File: rtl/seq_sm_multiplier.sv
// Shift-add multiplier on operand magnitudes with early termination once the
// remaining multiplier bits are all zero; returns magnitude, signed product and display sign.
module seq_sm_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    seq_sm_multiplier_if.slave   bus
);
    localparam logic [3:0] SIGN_NEG = 4'b1010;
    localparam logic [3:0] SIGN_POS = 4'b1100;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   mcand_sh;
    logic [WIDTH-1:0]     mplr_sh;
    logic [2*WIDTH-1:0]   acc;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg_in;
    logic                 accept;
    logic [WIDTH-1:0]     next_mplr;
    logic                 negz;

    // Mode 1 abs keeps the most negative value as its unsigned magnitude.
    always_comb begin
        mag_a = {1'b0, bus.multiplicand[WIDTH-2:0]};
        mag_b = {1'b0, bus.multiplier[WIDTH-2:0]};
        if (bus.mode) begin
            mag_a = bus.multiplicand[WIDTH-1] ? -bus.multiplicand : bus.multiplicand;
            mag_b = bus.multiplier[WIDTH-1]   ? -bus.multiplier   : bus.multiplier;
        end
        neg_in    = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
        accept    = bus.start && ((state == IDLE) || (state == DONE));
        next_mplr = mplr_sh >> 1;
        negz      = neg && (acc != '0);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state          <= IDLE;
            mcand_sh       <= '0;
            mplr_sh        <= '0;
            acc            <= '0;
            neg            <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.result     <= '0;
            bus.product_tc <= '0;
            bus.sign       <= SIGN_POS;
            bus.zflag      <= 1'b1;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: ;
                RUN: begin
                    if (mplr_sh[0]) begin
                        acc <= acc + mcand_sh;
                    end
                    mcand_sh <= mcand_sh << 1;
                    mplr_sh  <= next_mplr;
                    if (next_mplr == '0) begin
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                DONE: begin
                    bus.done       <= 1'b1;
                    bus.result     <= acc;
                    bus.product_tc <= negz ? -acc : acc;
                    bus.sign       <= negz ? SIGN_NEG : SIGN_POS;
                    bus.zflag      <= (acc == '0);
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A start seen in DONE overrides the return to IDLE, giving back-to-back runs.
            if (accept) begin
                neg      <= neg_in;
                mcand_sh <= {{WIDTH{1'b0}}, mag_a};
                mplr_sh  <= mag_b;
                acc      <= '0;
                if (mag_b == '0) begin
                    state    <= DONE;
                    bus.busy <= 1'b0;
                end else begin
                    state    <= RUN;
                    bus.busy <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_sm_multiplier.sv
// Self-checking bench for seq_sm_multiplier: directed scenarios plus random
// operands checked against an integer-arithmetic reference model.
module tb_seq_sm_multiplier;
    logic clock;
    logic rst;
    int   checks;
    int   errors;

    seq_sm_multiplier_if #(.WIDTH(8)) bus ();

    seq_sm_multiplier #(.WIDTH(8)) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: interpret operands as signed integers and multiply directly.
    task automatic model(input logic m, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] res, output logic [15:0] tc,
                         output logic [3:0] sg, output logic zf, output int n);
        int va, vb, p, mb;
        if (m) begin
            va = int'($signed(a));
            vb = int'($signed(b));
        end else begin
            va = a[7] ? -int'(a[6:0]) : int'(a[6:0]);
            vb = b[7] ? -int'(b[6:0]) : int'(b[6:0]);
        end
        p   = va * vb;
        res = 16'((p < 0) ? -p : p);
        tc  = 16'(p);
        sg  = (p < 0) ? 4'b1010 : 4'b1100;
        zf  = (p == 0);
        mb  = (vb < 0) ? -vb : vb;
        n   = $clog2(mb + 1);
    endtask

    task automatic run_op(input logic m, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cycles);
        @(negedge clock);
        bus.mode         = m;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        @(posedge clock);
        #1;
        bus.start   = 1'b0;
        busy_cycles = bus.busy ? 1 : 0;
        lat         = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.mode = 1'b0; bus.multiplicand = '0; bus.multiplier = '0;
        rst = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.result !== 16'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0000", bus.result); end
        checks++; if (bus.product_tc !== 16'h0) begin errors++; $display("[TB] FAIL reset_tc got %h want 0000", bus.product_tc); end
        checks++; if (bus.sign !== 4'b1100) begin errors++; $display("[TB] FAIL reset_sign got %b want 1100", bus.sign); end
        checks++; if (bus.zflag !== 1'b1) begin errors++; $display("[TB] FAIL reset_zflag got %b want 1", bus.zflag); end
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tm [3];
        logic [15:0] res, tc;
        logic [3:0]  sg;
        logic        zf;
        int n, lat, bc;
        ta = '{8'h85, 8'h80, 8'h83};
        tb = '{8'h07, 8'h80, 8'h00};
        tm = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            model(tm[i], ta[i], tb[i], res, tc, sg, zf, n);
            run_op(tm[i], ta[i], tb[i], lat, bc);
            checks++; if (lat !== n + 1) begin errors++; $display("[TB] FAIL dir%0d_latency got %0d want %0d", i, lat, n + 1); end
            checks++; if (bc !== n) begin errors++; $display("[TB] FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, n); end
            checks++; if (bus.result !== res) begin errors++; $display("[TB] FAIL dir%0d_result got %h want %h", i, bus.result, res); end
            checks++; if (bus.product_tc !== tc) begin errors++; $display("[TB] FAIL dir%0d_tc got %h want %h", i, bus.product_tc, tc); end
            checks++; if (bus.sign !== sg) begin errors++; $display("[TB] FAIL dir%0d_sign got %b want %b", i, bus.sign, sg); end
            checks++; if (bus.zflag !== zf) begin errors++; $display("[TB] FAIL dir%0d_zflag got %b want %b", i, bus.zflag, zf); end
            @(posedge clock);
            #1;
            checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_done_pulse got %b want 0", i, bus.done); end
            checks++; if (bus.result !== res) begin errors++; $display("[TB] FAIL dir%0d_hold got %h want %h", i, bus.result, res); end
        end
    endtask

    task automatic test_random();
        logic [15:0] res, tc;
        logic [3:0]  sg;
        logic        zf;
        logic [7:0]  a, b;
        logic        m;
        int n, lat, bc;
        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(1, 0));
            a = 8'($urandom);
            b = 8'($urandom) >> $urandom_range(7, 0);
            if ($urandom_range(1, 0) == 1) b[7] = 1'b1;
            model(m, a, b, res, tc, sg, zf, n);
            run_op(m, a, b, lat, bc);
            checks++; if (lat !== n + 1) begin errors++; $display("[TB] FAIL rnd_latency m=%b a=%h b=%h got %0d want %0d", m, a, b, lat, n + 1); end
            checks++; if (bus.result !== res) begin errors++; $display("[TB] FAIL rnd_result m=%b a=%h b=%h got %h want %h", m, a, b, bus.result, res); end
            checks++; if (bus.product_tc !== tc) begin errors++; $display("[TB] FAIL rnd_tc m=%b a=%h b=%h got %h want %h", m, a, b, bus.product_tc, tc); end
            checks++; if (bus.sign !== sg) begin errors++; $display("[TB] FAIL rnd_sign m=%b a=%h b=%h got %b want %b", m, a, b, bus.sign, sg); end
            checks++; if (bus.zflag !== zf) begin errors++; $display("[TB] FAIL rnd_zflag m=%b a=%h b=%h got %b want %b", m, a, b, bus.zflag, zf); end
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        lat = -1;
        @(negedge clock);
        bus.mode = 1'b1; bus.multiplicand = 8'h03; bus.multiplier = 8'hFD; bus.start = 1'b1;
        @(negedge clock);
        bus.multiplicand = 8'h7F; bus.multiplier = 8'h7F;
        @(negedge clock);
        bus.start = 1'b0;
        for (int k = 2; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL ignore_latency got %0d want 3", lat); end
        checks++; if (bus.result !== 16'd9) begin errors++; $display("[TB] FAIL ignore_result got %h want 0009", bus.result); end
        checks++; if (bus.product_tc !== 16'hFFF7) begin errors++; $display("[TB] FAIL ignore_tc got %h want fff7", bus.product_tc); end
        checks++; if (bus.sign !== 4'b1010) begin errors++; $display("[TB] FAIL ignore_sign got %b want 1010", bus.sign); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b00) begin errors++; $display("[TB] FAIL ignore_no_queue got %b want 00", {bus.busy, bus.done}); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, seen;
        seen = 0;
        @(negedge clock);
        bus.mode = 1'b0; bus.multiplicand = 8'h7F; bus.multiplier = 8'h7F; bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
        checks++; if (bus.result !== 16'h0) begin errors++; $display("[TB] FAIL abort_result got %h want 0000", bus.result); end
        checks++; if (bus.zflag !== 1'b1) begin errors++; $display("[TB] FAIL abort_zflag got %b want 1", bus.zflag); end
        @(negedge clock);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_done got %0d active cycles want 0", seen); end
        run_op(1'b0, 8'h02, 8'h03, lat, bc);
        checks++; if (bus.result !== 16'd6) begin errors++; $display("[TB] FAIL abort_followup got %h want 0006", bus.result); end
        checks++; if (lat !== 3) begin errors++; $display("[TB] FAIL abort_followup_latency got %0d want 3", lat); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        logic busy_after;
        lat1 = -1; lat2 = -1; busy_after = 1'b0;
        @(negedge clock);
        bus.mode = 1'b0; bus.multiplicand = 8'h02; bus.multiplier = 8'h03; bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.multiplicand = 8'h04; bus.multiplier = 8'h05;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat1 = k;
                break;
            end
        end
        bus.start  = 1'b0;
        busy_after = bus.busy;
        checks++; if (lat1 !== 3) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 3", lat1); end
        checks++; if (bus.result !== 16'd6) begin errors++; $display("[TB] FAIL b2b_first_result got %h want 0006", bus.result); end
        checks++; if (busy_after !== 1'b1) begin errors++; $display("[TB] FAIL b2b_no_gap got busy %b want 1", busy_after); end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                lat2 = k;
                break;
            end
        end
        checks++; if (lat2 !== 4) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 4", lat2); end
        checks++; if (bus.result !== 16'd20) begin errors++; $display("[TB] FAIL b2b_second_result got %h want 0014", bus.result); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_start_during_run();
        test_reset_mid_run();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
